// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stall-sequencer state encoding and register-index width.
package cpu_pkg;

   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } stall_state_t;

endpackage : cpu_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers read in ID.
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int unsigned REG_W = cpu_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_reg,
   output logic             load_use
);

   always_comb begin
      load_use = 1'b0;
      // x0 is hardwired zero, so a load targeting it can never create a dependency
      if (ex_mem_reg && (ex_rd != '0)) begin
         load_use = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd));
      end
   end

endmodule : hazard_detect

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, branch, dmem wait,
// wait-timeout watchdog with sticky fault, and saturating stall-cycle counter.
module pipe_stall_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned REG_W          = cpu_pkg::REG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_reg,
   input  logic             ex_branch_tkn,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             mem_wb_flush,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   stall_state_t      state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              load_use;
   logic              mem_stall;
   logic              stall_inc;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_mem_reg (ex_mem_reg),
      .load_use   (load_use)
   );

   assign mem_stall = (state != FAULT) && mem_access && !dmem_ready;
   assign fault     = (state == FAULT);
   assign stall_inc = !reset && !pc_en && (state != FAULT);

   always_comb begin
      dmem_req     = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b0;
      if (!reset && (state != FAULT)) begin
         dmem_req = mem_access;
         if (mem_stall) begin
            // MEM/WB takes a bubble so the held instruction is not written back twice
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
         end else if (ex_branch_tkn) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
         end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
         end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            // a dropped mem_access also releases the wait
            if (!mem_stall) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
               state_nxt = FAULT;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         FAULT:   state_nxt = FAULT;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         wait_cnt     <= '0;
         stall_cycles <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
      end
   end

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then randomized traffic
// compared against a behavioural model tracking consecutive wait cycles.
module tb_pipe_stall_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 6;
   localparam int unsigned RW = 5;
   localparam logic [63:0] SAT = (64'd1 << CW) - 64'd1;

   logic          clk = 1'b0;
   logic          reset;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_reg, ex_branch_tkn;
   logic          mem_access, dmem_ready;
   logic          dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic          ex_mem_en, mem_wb_en, mem_wb_flush, fault;
   logic [CW-1:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // model: fault flag, length of the current run of stalled memory cycles, stall total
   bit          m_fault;
   int          m_wait_run;
   logic [63:0] m_stalls;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW),
      .REG_W          (RW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .ex_rd         (ex_rd),
      .ex_mem_reg    (ex_mem_reg),
      .ex_branch_tkn (ex_branch_tkn),
      .mem_access    (mem_access),
      .dmem_ready    (dmem_ready),
      .dmem_req      (dmem_req),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .if_id_flush   (if_id_flush),
      .id_ex_en      (id_ex_en),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_en     (ex_mem_en),
      .mem_wb_en     (mem_wb_en),
      .mem_wb_flush  (mem_wb_flush),
      .fault         (fault),
      .stall_cycles  (stall_cycles)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ctrl_vec();
      return {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
              ex_mem_en, mem_wb_en, mem_wb_flush};
   endfunction

   // Expected {dmem_req,pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_en,mem_wb_flush}
   function automatic logic [8:0] ref_ctrl();
      bit hazard;
      if (reset || m_fault) return 9'b0;
      hazard = ex_mem_reg && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (mem_access && !dmem_ready) return {1'b1, 8'b0000_0011};
      if (ex_branch_tkn)             return {mem_access, 8'b1111_1110};
      if (hazard)                    return {mem_access, 8'b0001_1110};
      return {mem_access, 8'b1101_0110};
   endfunction

   task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit ld, input bit br, input bit macc, input bit rdy);
      id_rs1        = RW'(rs1);
      id_rs2        = RW'(rs2);
      id_use_rs1    = u1;
      id_use_rs2    = u2;
      ex_rd         = RW'(rd);
      ex_mem_reg    = ld;
      ex_branch_tkn = br;
      mem_access    = macc;
      dmem_ready    = rdy;
   endtask

   // Called at a negedge with inputs applied; checks, advances one clock, returns at next negedge.
   task automatic step(input string tag);
      logic [8:0] exp;
      #1;
      exp = ref_ctrl();
      check_val({tag, "_ctrl"}, 64'(ctrl_vec()), 64'(exp));
      check_val({tag, "_fault"}, 64'(fault), 64'(m_fault));
      check_val({tag, "_cnt"}, 64'(stall_cycles), m_stalls);
      @(posedge clk);
      if (!m_fault) begin
         if (!exp[7] && m_stalls != SAT) m_stalls = m_stalls + 1;
         if (mem_access && !dmem_ready) begin
            m_wait_run++;
            if (m_wait_run > int'(TO)) m_fault = 1'b1;
         end else begin
            m_wait_run = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      m_fault    = 1'b0;
      m_wait_run = 0;
      m_stalls   = '0;
      check_val({tag, "_rst_ctrl"}, 64'(ctrl_vec()), 64'd0);
      check_val({tag, "_rst_cnt"}, 64'(stall_cycles), 64'd0);
      check_val({tag, "_rst_fault"}, 64'(fault), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      do_reset("init");

      // load-use on rs1, then EX holds the bubble
      set_in(5, 0, 1, 0, 5, 1, 0, 0, 0);
      step("lu");
      set_in(5, 0, 1, 0, 0, 0, 0, 0, 0);
      step("lu_next");
      check_val("lu_total", 64'(stall_cycles), 64'd1);

      // load to x0 never stalls
      set_in(0, 0, 1, 0, 0, 1, 0, 0, 0);
      step("lu_x0");

      // three-cycle memory wait then release
      do_reset("mw");
      for (int i = 0; i < 3; i++) begin
         set_in(1, 2, 1, 1, 3, 0, 0, 1, 0);
         step("mwait");
      end
      set_in(1, 2, 1, 1, 3, 0, 0, 1, 1);
      step("mw_rel");
      check_val("mw_total", 64'(stall_cycles), 64'd3);

      // branch squashes a simultaneous load-use
      set_in(7, 0, 1, 0, 7, 1, 1, 0, 0);
      step("br_lu");

      // branch held through a memory stall is applied on release
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step("br_hold");
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
      step("br_rel");

      // watchdog: TO+1 consecutive wait cycles raise fault, ready afterwards is ignored
      do_reset("wd");
      for (int i = 0; i < int'(TO) + 1; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
         step("wd_wait");
      end
      check_val("wd_fault", 64'(fault), 64'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("wd_ready");
      step("wd_sticky");
      do_reset("wd_clr");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("wd_run");

      // async reset in the middle of a memory wait
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
         step("mid_wait");
      end
      #2;
      do_reset("mid");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("mid_run");

      // counter saturation via back-to-back load-use stalls
      for (int i = 0; i < 70; i++) begin
         set_in(9, 9, 0, 1, 9, 1, 0, 0, 0);
         step("sat");
      end
      check_val("sat_total", 64'(stall_cycles), SAT);

      // randomized traffic
      do_reset("rnd");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            do_reset("rnd");
         end
         set_in($urandom_range(0, 3), $urandom_range(0, 3),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 3), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0));
         step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_stall_ctrl
